l1_cache_responder: RTL and testbench
=====================================

Name: l1_cache_responder

Overview:
- Direct-mapped, write-back, write-allocate L1 cache; the responder end of the CPU-side cache interface driven by the pipelined datapath (instantiated once as I-cache, once as D-cache).
- Serves 32-bit word requests with byte enables and answers with resp/rdata; a hit completes in the same cycle.
- On a miss it becomes initiator on a 256-bit cacheline physical-memory interface: write back the dirty victim, then fill.

Parameters:
S_INDEX, 3, index bits (2^S_INDEX sets).
S_OFFSET, 5, line offset bits (32-byte line = 256 bits); tag width = 32 - S_INDEX - S_OFFSET.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
mem_read  input  1  CPU read request; held stable until mem_resp
mem_write  input  1  CPU write request; held stable until mem_resp
mem_address  input  32  byte address; [1:0] ignored for indexing
mem_wdata  input  32  write data, already lane-aligned
mem_byte_enable  input  4  byte lanes to write
mem_resp  output  1  request complete this cycle
mem_rdata  output  32  addressed word of the line; valid when mem_resp=1
pmem_read  output  1  line fill request
pmem_write  output  1  line writeback request
pmem_address  output  32  line-aligned address ([S_OFFSET-1:0]=0)
pmem_wdata  output  256  victim line
pmem_rdata  input  256  fill line
pmem_resp  input  1  pmem transaction done (one-cycle pulse)

Behaviour:
- Storage in flops: valid[set], dirty[set], tag[set], data[set]. Reads are combinational. valid and dirty clear asynchronously on rst. Tag/data are not reset.
- Decode: index = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET]; word = mem_address[S_OFFSET-1:2]; hit = valid[index] & (tag[index] == address tag).
- Request present = mem_read | mem_write. If both are asserted, treat the request as a write.
- FSM states: IDLE, WRITEBACK, FILL. Reset state is IDLE.
- IDLE, hit:
  - mem_resp=1 combinationally in the same cycle; mem_rdata = data[index][word].
  - On a write, at the clock edge, overwrite only the bytes enabled by mem_byte_enable within that word and set dirty=1.
  - Stay in IDLE. Back-to-back hits respond every cycle.
- IDLE, miss: mem_resp=0. If valid&dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - pmem_write=1; pmem_address={victim tag, index, 0}; pmem_wdata=data[index].
  - Hold these until pmem_resp, then go to FILL.
- FILL:
  - pmem_read=1; pmem_address={request tag, index, 0}.
  - On the edge where pmem_resp=1: data<=pmem_rdata, tag<=request tag, valid<=1, dirty<=0, go to IDLE.
  - The following cycle hits. Miss latency = 1 cycle after the final pmem_resp.
- pmem_resp outside WRITEBACK/FILL is ignored. pmem_read and pmem_write are never asserted together.
- Request dropped mid-miss: the current pmem transaction completes. After WRITEBACK, go to FILL only if a request is still present, else go to IDLE. A completed FILL installs the line without mem_resp.
- Reset values: mem_resp=0, pmem_read=0, pmem_write=0. pmem_address, pmem_wdata and mem_rdata are don't-care.
- While rst=1, all outputs above are forced to 0 immediately, including mid-WRITEBACK/FILL. After release the cache is empty.

Decomposition:
- Package cache_types: state enum (IDLE/WRITEBACK/FILL), tag/index/offset width localparams, line_t (256-bit) typedef.
- Sub-module cache_array: valid/dirty/tag/data storage with async clear of valid/dirty, line write and masked word write ports.
- FSM and hit logic stay in the top.

Test Plan:
- Clean read miss: read 0x00000024, pmem_rdata word1=0xDEADBEEF -> pmem_read=1 with pmem_address=0x00000020, no pmem_write; mem_resp=1 and mem_rdata=0xDEADBEEF exactly 1 cycle after pmem_resp.
- Write hit byte: write 0x00000025, mbe=0010, wdata=0x0000AB00 -> mem_resp same cycle, no pmem activity; subsequent read of 0x24 returns 0xDEADABEF.
- Dirty eviction: read 0x00000124 (same set 1, new tag) -> pmem_write first with pmem_address=0x00000020 and pmem_wdata word1=0xDEADABEF; then pmem_read with address 0x00000120; then mem_resp.
- Back-to-back hits: reads 0x20, 0x24, 0x28 on consecutive cycles after fill -> mem_resp=1 every cycle, correct words, pmem idle.
- Async reset mid-FILL: assert rst between clock edges while pmem_read=1 -> pmem_read=0 and mem_resp=0 immediately; after release, read 0x24 misses again (pmem_read=1).
- Read+write both asserted on a hit to 0x28, mbe=1111, wdata=0x12345678 -> handled as a write; a later read returns 0x12345678.

Source files
------------

// File: rtl/l1_cache_responder_pkg.sv
// ============================================================================
// Module      : cache_types (package)
// Description : Shared widths, line type and controller state encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_types;

  localparam int c_INDEX_W    = 3;
  localparam int c_OFFSET_W   = 5;
  localparam int c_TAG_W      = 32 - c_INDEX_W - c_OFFSET_W;
  localparam int c_LINE_BITS  = 256;
  localparam int c_WORD_SEL_W = c_OFFSET_W - 2;

  typedef logic [c_LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/l1_cache_responder_if.sv
// ============================================================================
// Module      : l1_cache_responder_if
// Description : CPU-side word bus plus physical-memory line bus of the L1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l1_cache_responder_if;
  import cache_types::*;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  line_t       pmem_wdata;
  line_t       pmem_rdata;
  logic        pmem_resp;

  // slave: the cache itself; master: the CPU datapath plus memory side
  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

`default_nettype wire

// File: rtl/l1_cache_responder_cache_array.sv
// ============================================================================
// Module      : cache_array
// Description : valid/dirty/tag/data flop storage, line fill and masked word write
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_array
  import cache_types::*;
#(
  parameter int S_INDEX    = c_INDEX_W,
  parameter int S_TAG      = c_TAG_W,
  parameter int WORD_SEL_W = c_WORD_SEL_W
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [S_INDEX-1:0]    index,
  output logic                       rd_valid,
  output logic                       rd_dirty,
  output logic [S_TAG-1:0]           rd_tag,
  output line_t                      rd_line,
  input  wire logic                  line_we,
  input  wire logic [S_TAG-1:0]      line_tag,
  input  wire line_t                 line_wdata,
  input  wire logic                  word_we,
  input  wire logic [WORD_SEL_W-1:0] word_sel,
  input  wire logic [31:0]           word_wdata,
  input  wire logic [3:0]            byte_en
);

  localparam int c_SETS = 1 << S_INDEX;

  logic [c_SETS-1:0] r_valid;
  logic [c_SETS-1:0] r_dirty;
  logic [S_TAG-1:0]  r_tag  [c_SETS];
  line_t             r_data [c_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (line_we) begin
      r_valid[index] <= 1'b1;
      r_dirty[index] <= 1'b0;
    end else if (word_we) begin
      r_dirty[index] <= 1'b1;
    end
  end

  // Tag and data carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      r_tag[index]  <= line_tag;
      r_data[index] <= line_wdata;
    end else if (word_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          r_data[index][32*int'(word_sel) + 8*b +: 8] <= word_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_valid = r_valid[index];
  assign rd_dirty = r_dirty[index];
  assign rd_tag   = r_tag[index];
  assign rd_line  = r_data[index];

endmodule

`default_nettype wire

// File: rtl/l1_cache_responder.sv
// ============================================================================
// Module      : l1_cache_responder
// Description : Direct-mapped write-back/write-allocate L1 with line refill FSM
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_cache_responder
  import cache_types::*;
#(
  parameter int S_INDEX  = c_INDEX_W,
  parameter int S_OFFSET = c_OFFSET_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  l1_cache_responder_if.slave   bus
);

  localparam int c_S_TAG      = 32 - S_INDEX - S_OFFSET;
  localparam int c_WORD_SEL_W = S_OFFSET - 2;

  state_t                  r_state;
  logic [S_INDEX-1:0]      w_index;
  logic [c_WORD_SEL_W-1:0] w_word;
  logic [c_S_TAG-1:0]      w_req_tag;
  logic                    w_req;
  logic                    w_hit;
  logic                    w_set_valid;
  logic                    w_set_dirty;
  logic [c_S_TAG-1:0]      w_set_tag;
  line_t                   w_set_line;
  logic                    w_line_we;
  logic                    w_word_we;

  assign w_index   = bus.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_word    = bus.mem_address[S_OFFSET-1:2];
  assign w_req_tag = bus.mem_address[31:S_OFFSET+S_INDEX];
  assign w_req     = bus.mem_read | bus.mem_write;
  assign w_hit     = w_set_valid && (w_set_tag == w_req_tag);

  // A write wins when read and write are raised together.
  assign w_word_we = (r_state == IDLE) && w_hit && bus.mem_write;
  assign w_line_we = (r_state == FILL) && bus.pmem_resp;

  cache_array #(
    .S_INDEX    (S_INDEX),
    .S_TAG      (c_S_TAG),
    .WORD_SEL_W (c_WORD_SEL_W)
  ) u_cache_array (
    .clk        (clk),
    .rst        (rst),
    .index      (w_index),
    .rd_valid   (w_set_valid),
    .rd_dirty   (w_set_dirty),
    .rd_tag     (w_set_tag),
    .rd_line    (w_set_line),
    .line_we    (w_line_we),
    .line_tag   (w_req_tag),
    .line_wdata (bus.pmem_rdata),
    .word_we    (w_word_we),
    .word_sel   (w_word),
    .word_wdata (bus.mem_wdata),
    .byte_en    (bus.mem_byte_enable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_hit) begin
            r_state <= (w_set_valid && w_set_dirty) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          // A request abandoned during writeback skips the refill.
          if (bus.pmem_resp) begin
            r_state <= w_req ? FILL : IDLE;
          end
        end
        FILL: begin
          if (bus.pmem_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_resp   = !rst && (r_state == IDLE) && w_req && w_hit;
  assign bus.mem_rdata  = w_set_line[32*int'(w_word) +: 32];
  assign bus.pmem_read  = !rst && (r_state == FILL);
  assign bus.pmem_write = !rst && (r_state == WRITEBACK);
  assign bus.pmem_wdata = w_set_line;
  assign bus.pmem_address = (r_state == WRITEBACK)
                          ? {w_set_tag, w_index, {S_OFFSET{1'b0}}}
                          : {w_req_tag, w_index, {S_OFFSET{1'b0}}};

endmodule

`default_nettype wire

// File: tb/tb_l1_cache_responder.sv
// ============================================================================
// Module      : tb_l1_cache_responder
// Description : Directed self-checking bench for the L1 cache responder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_cache_responder;
  import cache_types::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  line_t line_a;
  line_t line_b;

  l1_cache_responder_if bus ();

  l1_cache_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) begin
      line_a[i*32 +: 32] = 32'h1000_0000 + i;
      line_b[i*32 +: 32] = 32'h2000_0000 + i;
    end
    line_a[63:32] = 32'hDEAD_BEEF;

    rst                 = 1'b1;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = 32'h0;
    bus.mem_wdata       = 32'h0;
    bus.mem_byte_enable = 4'h0;
    bus.pmem_rdata      = '0;
    bus.pmem_resp       = 1'b0;
    #3;
    check("rst_mem_resp",   bus.mem_resp,   0);
    check("rst_pmem_read",  bus.pmem_read,  0);
    check("rst_pmem_write", bus.pmem_write, 0);
    tick();
    tick();
    rst = 1'b0;

    // Clean read miss on 0x24
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_0024;
    #1 check("miss_no_resp", bus.mem_resp, 0);
    tick(); #1;
    check("fill_pmem_read",  bus.pmem_read,    1);
    check("fill_pmem_write", bus.pmem_write,   0);
    check("fill_addr",       bus.pmem_address, 32'h0000_0020);
    check("fill_wait_resp",  bus.mem_resp,     0);
    tick();
    bus.pmem_rdata = line_a;
    bus.pmem_resp  = 1'b1;
    #1 check("fill_edge_no_resp", bus.mem_resp, 0);
    tick();
    bus.pmem_resp = 1'b0;
    #1;
    check("fill_done_resp",  bus.mem_resp,  1);
    check("fill_done_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    check("fill_done_idle",  bus.pmem_read, 0);

    // Byte write hit
    tick();
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b1;
    bus.mem_address     = 32'h0000_0025;
    bus.mem_wdata       = 32'h0000_AB00;
    bus.mem_byte_enable = 4'b0010;
    #1;
    check("wr_hit_resp",  bus.mem_resp,   1);
    check("wr_hit_pread", bus.pmem_read,  0);
    check("wr_hit_pwrite", bus.pmem_write, 0);

    // Back-to-back read hits
    tick();
    bus.mem_write   = 1'b0;
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_0020;
    #1;
    check("b2b0_resp",  bus.mem_resp,  1);
    check("b2b0_rdata", bus.mem_rdata, 32'h1000_0000);
    tick();
    bus.mem_address = 32'h0000_0024;
    #1;
    check("b2b1_resp",  bus.mem_resp,  1);
    check("b2b1_rdata", bus.mem_rdata, 32'hDEAD_ABEF);
    tick();
    bus.mem_address = 32'h0000_0028;
    #1;
    check("b2b2_resp",  bus.mem_resp,  1);
    check("b2b2_rdata", bus.mem_rdata, 32'h1000_0002);
    check("b2b2_pread", bus.pmem_read, 0);

    // Read and write together on a hit act as a write
    tick();
    bus.mem_write       = 1'b1;
    bus.mem_byte_enable = 4'b1111;
    bus.mem_wdata       = 32'h1234_5678;
    #1;
    check("rw_resp",   bus.mem_resp,   1);
    check("rw_pwrite", bus.pmem_write, 0);
    tick();
    bus.mem_write = 1'b0;
    #1 check("rw_readback", bus.mem_rdata, 32'h1234_5678);

    // Dirty eviction: 0x124 maps to set 1 with a new tag
    tick();
    bus.mem_address = 32'h0000_0124;
    #1 check("evict_no_resp", bus.mem_resp, 0);
    tick(); #1;
    check("wb_pwrite", bus.pmem_write,         1);
    check("wb_pread",  bus.pmem_read,          0);
    check("wb_addr",   bus.pmem_address,       32'h0000_0020);
    check("wb_word0",  bus.pmem_wdata[31:0],   32'h1000_0000);
    check("wb_word1",  bus.pmem_wdata[63:32],  32'hDEAD_ABEF);
    check("wb_word2",  bus.pmem_wdata[95:64],  32'h1234_5678);
    check("wb_no_resp", bus.mem_resp,          0);
    tick();
    bus.pmem_resp = 1'b1;
    #1 check("wb_hold", bus.pmem_write, 1);
    tick();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = line_b;
    #1;
    check("evfill_pread",  bus.pmem_read,    1);
    check("evfill_pwrite", bus.pmem_write,   0);
    check("evfill_addr",   bus.pmem_address, 32'h0000_0120);
    tick();
    bus.pmem_resp = 1'b1;
    #1 check("evfill_edge_no_resp", bus.mem_resp, 0);
    tick();
    bus.pmem_resp = 1'b0;
    #1;
    check("evict_resp",  bus.mem_resp,  1);
    check("evict_rdata", bus.mem_rdata, 32'h2000_0001);

    // Async reset while a clean-miss FILL is outstanding
    tick();
    bus.mem_address = 32'h0000_0024;
    #1 check("clean_miss_no_resp", bus.mem_resp, 0);
    tick(); #1;
    check("rstfill_pread",  bus.pmem_read,  1);
    check("rstfill_pwrite", bus.pmem_write, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pread",  bus.pmem_read,  0);
    check("async_rst_pwrite", bus.pmem_write, 0);
    check("async_rst_resp",   bus.mem_resp,   0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_resp",  bus.mem_resp,  0);
    check("post_rst_pread", bus.pmem_read, 0);
    tick(); #1;
    check("post_rst_miss",   bus.pmem_read,    1);
    check("post_rst_addr",   bus.pmem_address, 32'h0000_0020);
    check("post_rst_pwrite", bus.pmem_write,   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
